// File: rtl/audio_sample_fifo_if.sv
// iomem-bus request/response bundle for the audio sample FIFO peripheral.
// Handshake: the slave accepts one access when iomem_valid && sel && !iomem_ready and
// answers with a single-cycle iomem_ready pulse, with iomem_rdata valid in that cycle.
interface audio_sample_fifo_if;
  logic        iomem_valid;
  logic        sel;
  logic [7:0]  iomem_addr;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;

  modport master (
    output iomem_valid, sel, iomem_addr, iomem_wstrb, iomem_wdata,
    input  iomem_rdata, iomem_ready
  );

  modport slave (
    input  iomem_valid, sel, iomem_addr, iomem_wstrb, iomem_wdata,
    output iomem_rdata, iomem_ready
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// CPU-filled sample FIFO drained by a programmable sample-rate timer, feeding the
// PDM DAC so playback timing does not depend on when the CPU gets around to writing.
module audio_sample_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int SAMPLE_W    = 12,
  parameter int DEFAULT_DIV = 1999
) (
  input  logic                clk,
  input  logic                resetn,
  audio_sample_fifo_if.slave  bus,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_tick,
  output logic                irq_low
);
  localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [15:0]         DIV_RST  = 16'(DEFAULT_DIV);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_HALF = (DEPTH_LOG2 + 1)'(DEPTH / 2);

  logic [SAMPLE_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_level, w_level_next;
  logic [15:0]           r_div, r_cnt;
  logic                  r_enable, r_irq_en, r_unf, r_ovf;
  logic                  r_ready, r_tick, r_irq;
  logic [31:0]           r_rdata, w_rdata;
  logic [SAMPLE_W-1:0]   r_sample;

  logic w_access, w_wr, w_empty, w_full, w_tick, w_flush;
  logic w_push, w_pop, w_push_ok, w_unf_set, w_ovf_set, w_stat_wr, w_ctrl_wr, w_div_wr;

  assign w_access  = bus.iomem_valid & bus.sel & ~r_ready;
  assign w_wr      = w_access & (|bus.iomem_wstrb);
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_FULL);
  assign w_tick    = r_enable & (r_cnt == 16'd0);
  assign w_ctrl_wr = w_wr & (bus.iomem_addr == 8'h0C);
  assign w_stat_wr = w_wr & (bus.iomem_addr == 8'h08);
  assign w_div_wr  = w_wr & (bus.iomem_addr == 8'h04);
  assign w_push    = w_wr & (bus.iomem_addr == 8'h00);
  assign w_flush   = w_ctrl_wr & bus.iomem_wdata[1];
  // A flush cancels the tick's pop entirely, so it cannot also report underflow.
  assign w_pop     = w_tick & ~w_flush & ~w_empty;
  assign w_unf_set = w_tick & ~w_flush & w_empty;
  // When full, a same-cycle pop frees the slot the push needs.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_comb begin
    w_level_next = r_level;
    if (w_flush)                w_level_next = '0;
    else if (w_push_ok & ~w_pop) w_level_next = r_level + 1'b1;
    else if (w_pop & ~w_push_ok) w_level_next = r_level - 1'b1;
  end

  always_comb begin
    w_rdata = '0;
    case (bus.iomem_addr)
      8'h04: w_rdata[15:0] = r_div;
      8'h08: begin
        w_rdata[DEPTH_LOG2:0] = r_level;
        w_rdata[8]            = w_empty;
        w_rdata[9]            = w_full;
        w_rdata[16]           = r_unf;
        w_rdata[17]           = r_ovf;
      end
      8'h0C: begin
        w_rdata[0] = r_enable;
        w_rdata[2] = r_irq_en;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= bus.iomem_wdata[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_div    <= DIV_RST;
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
      r_unf    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ready <= w_access;
      if (w_access) r_rdata <= w_rdata;
      if (w_div_wr && bus.iomem_wstrb[0]) r_div[7:0]  <= bus.iomem_wdata[7:0];
      if (w_div_wr && bus.iomem_wstrb[1]) r_div[15:8] <= bus.iomem_wdata[15:8];
      if (w_ctrl_wr) begin
        r_enable <= bus.iomem_wdata[0];
        r_irq_en <= bus.iomem_wdata[2];
      end
      // A flag raised in the same cycle as its clear wins, so no event is lost.
      r_unf <= (r_unf & ~(w_stat_wr & bus.iomem_wdata[16])) | w_unf_set;
      r_ovf <= (r_ovf & ~(w_stat_wr & bus.iomem_wdata[17])) | w_ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt  <= DIV_RST;
      r_tick <= 1'b0;
    end else if (!r_enable || w_tick) begin
      r_cnt  <= r_div;
      r_tick <= w_tick;
    end else begin
      r_cnt  <= r_cnt - 16'd1;
      r_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_sample <= SAMPLE_W'(1) << (SAMPLE_W - 1);
      r_irq    <= 1'b0;
    end else begin
      r_level <= w_level_next;
      r_irq   <= r_enable & r_irq_en & (r_level <= LVL_HALF);
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + 1'b1;
        if (w_pop) begin
          r_rptr   <= r_rptr + 1'b1;
          r_sample <= r_mem[r_rptr];
        end
      end
    end
  end

  assign bus.iomem_ready = r_ready;
  assign bus.iomem_rdata = r_rdata;
  assign sample_out      = r_sample;
  assign sample_tick     = r_tick;
  assign irq_low         = r_irq;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed and randomized checks of audio_sample_fifo against a queue-based model
// that is stepped once per clock with the same bus inputs the DUT sees.
module tb_audio_sample_fifo;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  audio_sample_fifo_if bus ();
  logic [11:0] sample_out;
  logic        sample_tick;
  logic        irq_low;

  audio_sample_fifo #(.DEPTH_LOG2(4), .SAMPLE_W(12), .DEFAULT_DIV(1999)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus.slave),
    .sample_out  (sample_out),
    .sample_tick (sample_tick),
    .irq_low     (irq_low)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a queue, registers as plain variables.
  logic [11:0] exp_q[$];
  logic [15:0] m_div;
  int          m_cnt;
  bit          m_en, m_irqen, m_unf, m_ovf, m_ready, m_tick, m_irq;
  logic [11:0] m_sample;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_div = 16'd1999; m_cnt = 1999;
    m_en = 0; m_irqen = 0; m_unf = 0; m_ovf = 0;
    m_ready = 0; m_tick = 0; m_irq = 0;
    m_sample = 12'h800; m_rdata = '0;
  endtask

  function automatic logic [31:0] m_reg(input logic [7:0] a);
    int n;
    n = exp_q.size();
    case (a)
      8'h04: return {16'h0, m_div};
      8'h08: return {14'b0, m_ovf, m_unf, 6'b0, (n == 16), (n == 0), 3'b0, 5'(n)};
      8'h0C: return {29'b0, m_irqen, 1'b0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit acc, wr, tick, flush;
    logic [7:0]  a;
    logic [31:0] d;
    if (!resetn) begin
      model_reset();
      return;
    end
    a = bus.iomem_addr; d = bus.iomem_wdata;
    acc = bus.iomem_valid && bus.sel && !m_ready;
    wr  = acc && (bus.iomem_wstrb != 4'h0);
    if (acc) m_rdata = m_reg(a);
    m_ready = acc;
    m_irq = m_en && m_irqen && (exp_q.size() <= 8);
    tick = m_en && (m_cnt == 0);
    m_tick = tick;
    if (!m_en || m_cnt == 0) m_cnt = m_div; else m_cnt--;
    if (wr && a == 8'h08) begin
      if (d[16]) m_unf = 0;
      if (d[17]) m_ovf = 0;
    end
    flush = wr && a == 8'h0C && d[1];
    if (tick && !flush) begin
      if (exp_q.size() > 0) m_sample = exp_q.pop_front();
      else m_unf = 1;
    end
    if (wr && a == 8'h00) begin
      if (exp_q.size() < 16) exp_q.push_back(d[11:0]);
      else m_ovf = 1;
    end
    if (flush) exp_q.delete();
    if (wr && a == 8'h04) begin
      if (bus.iomem_wstrb[0]) m_div[7:0]  = d[7:0];
      if (bus.iomem_wstrb[1]) m_div[15:8] = d[15:8];
    end
    if (wr && a == 8'h0C) begin
      m_en = d[0];
      m_irqen = d[2];
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("sample_out", {20'h0, sample_out}, {20'h0, m_sample});
    check("sample_tick", {31'h0, sample_tick}, {31'h0, m_tick});
    check("irq_low", {31'h0, irq_low}, {31'h0, m_irq});
    check("ready", {31'h0, bus.iomem_ready}, {31'h0, m_ready});
    check("rdata", bus.iomem_rdata, m_rdata);
  endtask

  task automatic bus_access(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                            output logic [31:0] rd);
    int n;
    n = 0;
    bus.iomem_valid = 1'b1; bus.sel = 1'b1;
    bus.iomem_addr = a; bus.iomem_wstrb = s; bus.iomem_wdata = d;
    do begin
      cycle();
      n++;
    end while (bus.iomem_ready !== 1'b1 && n < 4);
    check("ack_timeout", {31'h0, bus.iomem_ready}, 32'h1);
    rd = bus.iomem_rdata;
    bus.iomem_valid = 1'b0; bus.sel = 1'b0; bus.iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_access(a, 4'hF, d, dummy);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus_access(a, 4'h0, 32'h0, d);
  endtask

  task automatic run_until_tick();
    bit got;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      cycle();
      if (sample_tick === 1'b1) got = 1;
    end
    check("tick_timeout", {31'h0, got}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [11:0] sent[$];
    logic [11:0] seen[$];
    logic [11:0] x;
    int last;
    bus.iomem_valid = 0; bus.sel = 0; bus.iomem_addr = 0;
    bus.iomem_wstrb = 0; bus.iomem_wdata = 0;
    resetn = 1'b0;
    cycle(); cycle();
    resetn = 1'b1;

    // Reset values
    check("rst_sample", {20'h0, sample_out}, 32'h800);
    rd(8'h08, r); check("rst_stat", r, 32'h100);
    rd(8'h04, r); check("rst_div", r, 32'd1999);
    rd(8'h0C, r); check("rst_ctrl", r, 32'h0);

    // Playback at DIV=3: one tick every 4 clocks, then underflow holds last sample
    wr(8'h04, 32'd3);
    wr(8'h00, 32'h100);
    wr(8'h00, 32'h200);
    wr(8'h0C, 32'h1);
    last = -1;
    for (int i = 1; i <= 13; i++) begin
      cycle();
      if (sample_tick === 1'b1) begin
        seen.push_back(sample_out);
        if (last >= 0) check("tick_period", i - last, 4);
        last = i;
      end
    end
    check("tick_count", seen.size(), 3);
    while (seen.size() < 3) seen.push_back(12'hXXX);
    check("play0", {20'h0, seen[0]}, 32'h100);
    check("play1", {20'h0, seen[1]}, 32'h200);
    check("play_hold", {20'h0, seen[2]}, 32'h200);
    rd(8'h08, r); check("underflow_stat", r, 32'h10100);
    wr(8'h0C, 32'h0);
    wr(8'h08, 32'h30000);

    // Overfill while disabled
    for (int i = 0; i < 17; i++) begin
      x = 12'($urandom_range(0, 4095));
      sent.push_back(x);
      wr(8'h00, {20'h0, x});
    end
    rd(8'h08, r); check("overflow_stat", r, 32'h20210);
    wr(8'h08, 32'h20000);
    rd(8'h08, r); check("overflow_clr", r, 32'h210);

    // Push on the tick cycle while full
    bus_access(8'h04, 4'h3, 32'd20, r);
    wr(8'h0C, 32'h1);
    for (int i = 0; i < 100 && !(m_en && m_cnt == 0 && !m_ready); i++) cycle();
    x = 12'($urandom_range(0, 4095));
    wr(8'h00, {20'h0, x});
    check("full_tick_pop", {20'h0, sample_out}, {20'h0, sent[0]});
    rd(8'h08, r); check("full_tick_stat", r, 32'h210);
    for (int k = 1; k <= 16; k++) begin
      run_until_tick();
      check("drain_order", {20'h0, sample_out}, {20'h0, (k < 16) ? sent[k] : x});
    end

    // Flush with 5 entries while enabling
    wr(8'h0C, 32'h0);
    wr(8'h08, 32'h30000);
    for (int i = 0; i < 5; i++) wr(8'h00, $urandom_range(0, 4095));
    wr(8'h0C, 32'h3);
    rd(8'h08, r); check("flush_stat", r, 32'h100);
    rd(8'h0C, r); check("flush_ctrl", r, 32'h1);
    run_until_tick();
    rd(8'h08, r); check("flush_underflow", r, 32'h10100);

    // Low-water IRQ, then reset mid-playback
    wr(8'h0C, 32'h2);
    wr(8'h08, 32'h30000);
    for (int i = 0; i < 8; i++) wr(8'h00, $urandom_range(0, 4095));
    wr(8'h0C, 32'h5);
    cycle();
    check("irq_half", {31'h0, irq_low}, 32'h1);
    wr(8'h00, $urandom_range(0, 4095));
    cycle();
    check("irq_above", {31'h0, irq_low}, 32'h0);
    run_until_tick();
    rd(8'h08, r); check("play_level", r, 32'h8);
    resetn = 1'b0;
    cycle();
    check("mid_rst_sample", {20'h0, sample_out}, 32'h800);
    check("mid_rst_tick", {31'h0, sample_tick}, 32'h0);
    check("mid_rst_irq", {31'h0, irq_low}, 32'h0);
    check("mid_rst_ready", {31'h0, bus.iomem_ready}, 32'h0);
    check("mid_rst_rdata", bus.iomem_rdata, 32'h0);
    resetn = 1'b1;
    rd(8'h08, r); check("post_rst_stat", r, 32'h100);

    // Randomized traffic against the model
    wr(8'h04, 32'd2);
    wr(8'h0C, 32'h5);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr(8'h00, $urandom);
        4: rd(8'h08, r);
        5: wr(8'h0C, {29'h0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) != 0)});
        6: bus_access(8'h04, 4'($urandom_range(0, 15)), $urandom_range(0, 6), r);
        7: wr(8'h08, {14'h0, 2'($urandom_range(0, 3)), 16'h0});
        8: begin
          bus.iomem_valid = 1'b1; bus.sel = 1'b0;
          bus.iomem_addr = 8'h00; bus.iomem_wstrb = 4'hF; bus.iomem_wdata = $urandom;
          cycle();
          bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0;
          repeat ($urandom_range(1, 4)) cycle();
        end
        default: bus_access(8'($urandom_range(16, 255)), 4'($urandom_range(0, 15)), $urandom, r);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
